// File: rtl/systolic_pkg.sv
// Shared types and constants for the 1x4 systolic PE row and its operand feeder.
package systolic_pkg;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int NUM_PE = 4;
  localparam int K_W    = 16;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    DRAIN,
    DONE
  } feeder_state_t;
endpackage

// File: rtl/sys_skew_line.sv
// One operand lane: a registered load stage followed by DEPTH delay stages.
// A cycle without a load shifts a zero in, so bubbles reach the PE as 0 operands.
module sys_skew_line #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] stage [DEPTH+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j <= DEPTH; j++) stage[j] <= '0;
    end else begin
      stage[0] <= load ? din : '0;
      for (int j = 1; j <= DEPTH; j++) stage[j] <= stage[j-1];
    end
  end

  assign dout = stage[DEPTH];
endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for a 1x4 systolic PE row: job FSM, beat/drain counters, skewed lanes.
// Optional stall counter output enabled by defining SYSTOLIC_FEEDER_STALL_CNT_EN.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int K_W    = 16,
  parameter int NUM_PE = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [K_W-1:0]           k_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_PE*DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0]        in_b,
  output logic                     arr_clr,
  output logic [DATA_W-1:0]        a0_o,
  output logic [DATA_W-1:0]        a1_o,
  output logic [DATA_W-1:0]        a2_o,
  output logic [DATA_W-1:0]        a3_o,
  output logic [DATA_W-1:0]        b0_o,
  output logic                     busy,
  output logic                     done,
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  output logic [K_W-1:0]           stall_cnt,
`endif
  output feeder_state_t            state
);
  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in RUN, and in_valid has no effect in any other state.
  localparam logic [1:0] DRAIN_INIT = 2'(NUM_PE - 1);

  feeder_state_t     next_state;
  logic [K_W-1:0]    beat_cnt;
  logic [1:0]        drain_cnt;
  logic              accept;
  logic              last_beat;
  logic [DATA_W-1:0] a_lane [NUM_PE];

  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (beat_cnt == K_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = CLR;
      CLR:     next_state = (beat_cnt == '0) ? DONE : RUN;
      RUN:     if (last_beat) next_state = DRAIN;
      DRAIN:   if (drain_cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign in_ready = (state == RUN);
  assign arr_clr  = (state == CLR);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == IDLE && start) beat_cnt <= k_len;
      else if (accept)            beat_cnt <= beat_cnt - K_W'(1);
      // Drain covers the extra hops PE3 needs after the last beat enters lane 0.
      if (last_beat)                            drain_cnt <= DRAIN_INIT;
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 2'd1;
    end
  end

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || state == CLR) begin
      stall_cnt <= '0;
    end else if (state == RUN && !in_valid && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + K_W'(1);
    end
  end
`endif

  sys_skew_line #(.DATA_W(DATA_W), .DEPTH(0)) u_b_lane (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .din  (in_b),
    .dout (b0_o)
  );

  for (genvar i = 0; i < NUM_PE; i++) begin : g_a_lane
    sys_skew_line #(.DATA_W(DATA_W), .DEPTH(i)) u_a_lane (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .din  (in_a[i*DATA_W +: DATA_W]),
      .dout (a_lane[i])
    );
  end

  assign a0_o = a_lane[0];
  assign a1_o = a_lane[1];
  assign a2_o = a_lane[2];
  assign a3_o = a_lane[3];
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder with an attached 1x4 PE row and a dot-product scoreboard.
module tb_systolic_feeder;
  import systolic_pkg::*;

  localparam int DW = 16;
  localparam int KW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, in_valid;
  logic [KW-1:0]     k_len;
  logic [4*DW-1:0]   in_a;
  logic [DW-1:0]     in_b;
  logic              in_ready, arr_clr, busy, done;
  logic [DW-1:0]     a0_o, a1_o, a2_o, a3_o, b0_o;
  feeder_state_t     state;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [KW-1:0]     stall_cnt;
`endif

  systolic_feeder dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .arr_clr(arr_clr), .a0_o(a0_o), .a1_o(a1_o), .a2_o(a2_o), .a3_o(a3_o),
    .b0_o(b0_o), .busy(busy), .done(done),
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .state(state)
  );

  // ---------------- downstream PE row ----------------
  logic [DW-1:0] bq [4];
  logic [31:0]   c  [4];
  always @(posedge clk) begin
    if (rst || arr_clr) begin
      for (int i = 0; i < 4; i++) begin
        bq[i] <= '0;
        c[i]  <= '0;
      end
    end else begin
      bq[1] <= b0_o;
      bq[2] <= bq[1];
      bq[3] <= bq[2];
      c[0]  <= c[0] + 32'(a0_o) * 32'(b0_o);
      c[1]  <= c[1] + 32'(a1_o) * 32'(bq[1]);
      c[2]  <= c[2] + 32'(a2_o) * 32'(bq[2]);
      c[3]  <= c[3] + 32'(a3_o) * 32'(bq[3]);
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag);
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() == 0) e = 32'hdead_beef;
      else                   e = exp_q.pop_front();
      check($sformatf("%s_c%0d", tag, i), c[i], e);
    end
  endtask

  // ---------------- driver ----------------
  logic [DW-1:0] ba [16][4];
  logic [DW-1:0] bb [16];
  int            gap [16];

  task automatic rand_beats(input int k, input int max_gap);
    for (int b = 0; b < k; b++) begin
      for (int i = 0; i < 4; i++) ba[b][i] = DW'($urandom);
      bb[b]  = DW'($urandom);
      gap[b] = $urandom_range(0, max_gap);
    end
  endtask

  // Called and returns right after a negedge, with the DUT in IDLE.
  task automatic run_job(input string tag, input int k, input bit start_in_drain);
    logic [31:0] s [4];
    int lat;
    int stalls;
    for (int i = 0; i < 4; i++) s[i] = '0;
    for (int b = 0; b < k; b++)
      for (int i = 0; i < 4; i++) s[i] = s[i] + 32'(ba[b][i]) * 32'(bb[b]);
    for (int i = 0; i < 4; i++) exp_q.push_back(s[i]);

    start = 1'b1; k_len = KW'(k); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_clr_on"}, arr_clr, 1'b1);
    check({tag, "_clr_ready"}, in_ready, 1'b0);
    check({tag, "_clr_busy"}, busy, 1'b1);
    in_valid = 1'b1; in_a = {$urandom, $urandom}; in_b = DW'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_clr_once"}, arr_clr, 1'b0);

    if (k == 0) begin
      check({tag, "_done_k0"}, done, 1'b1);
      check({tag, "_ready_k0"}, in_ready, 1'b0);
      check_results(tag);
    end else begin
      stalls = 0;
      for (int b = 0; b < k; b++) begin
        for (int g = 0; g < gap[b]; g++) begin
          in_valid = 1'b0; in_a = {$urandom, $urandom}; in_b = DW'($urandom);
          check({tag, "_ready_bubble"}, in_ready, 1'b1);
          stalls++;
          @(negedge clk);
        end
        in_valid = 1'b1;
        in_a = {ba[b][3], ba[b][2], ba[b][1], ba[b][0]};
        in_b = bb[b];
        check({tag, "_ready_beat"}, in_ready, 1'b1);
        @(negedge clk);
      end
      lat = 0;
      in_valid = 1'($urandom_range(0, 1)); in_a = {$urandom, $urandom}; in_b = DW'($urandom);
      while (done !== 1'b1 && lat < 12) begin
        check({tag, "_ready_drain"}, in_ready, 1'b0);
        if (start_in_drain && lat == 1) begin start = 1'b1; k_len = KW'(5); end
        if (lat == 2) start = 1'b0;
        @(negedge clk);
        lat++;
        in_valid = 1'($urandom_range(0, 1)); in_a = {$urandom, $urandom}; in_b = DW'($urandom);
      end
      start = 1'b0; in_valid = 1'b0;
      check({tag, "_done_latency"}, lat, 4);
      check_results(tag);
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
      check({tag, "_stall_cnt"}, stall_cnt, stalls);
`endif
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen_done;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; k_len = '0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    check("rst_state", state, IDLE);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_clr", arr_clr, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_lanes", {a3_o, a2_o, a1_o, a0_o}, 64'd0);
    check("rst_b0", b0_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single beat, a=(1,2,3,4), b=5.
    for (int i = 0; i < 4; i++) ba[0][i] = DW'(i + 1);
    bb[0] = 16'd5; gap[0] = 0;
    run_job("single", 1, 1'b0);

    // Three beats with two bubbles between beats 1 and 2.
    for (int i = 0; i < 4; i++) begin
      ba[0][i] = 16'd1; ba[1][i] = 16'd2; ba[2][i] = 16'd3;
    end
    bb[0] = 16'd1; bb[1] = 16'd3; bb[2] = 16'd2;
    gap[0] = 0; gap[1] = 2; gap[2] = 0;
    run_job("three", 3, 1'b0);

    run_job("empty", 0, 1'b0);

    // Back-to-back: start during DRAIN must be ignored, then an immediate next job.
    rand_beats(3, 1);
    run_job("b2b_a", 3, 1'b1);
    rand_beats(2, 1);
    run_job("b2b_b", 2, 1'b0);

    // Reset in the middle of RUN after two of four beats.
    start = 1'b1; k_len = KW'(4);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1; in_a = {$urandom, $urandom}; in_b = DW'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_lanes", {a3_o, a2_o, a1_o, a0_o}, 64'd0);
    check("midrst_b0", b0_o, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_ready", in_ready, 1'b0);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    check("midrst_no_done", seen_done, 1'b0);
    rand_beats(1, 0);
    run_job("after_rst", 1, 1'b0);

    // Skew: each lane carries the 7 only in its own cycle.
    start = 1'b1; k_len = KW'(1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_a = {16'd7, 16'd7, 16'd7, 16'd7}; in_b = 16'd1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      in_a = {$urandom, $urandom}; in_b = DW'($urandom);
      check($sformatf("skew_a0_t%0d", j), a0_o, (j == 0) ? 7 : 0);
      check($sformatf("skew_a1_t%0d", j), a1_o, (j == 1) ? 7 : 0);
      check($sformatf("skew_a2_t%0d", j), a2_o, (j == 2) ? 7 : 0);
      check($sformatf("skew_a3_t%0d", j), a3_o, (j == 3) ? 7 : 0);
      check($sformatf("skew_b0_t%0d", j), b0_o, (j == 0) ? 1 : 0);
      check($sformatf("skew_done_t%0d", j), done, (j == 4) ? 1 : 0);
      if (j == 4) begin
        for (int i = 0; i < 4; i++) check($sformatf("skew_c%0d", i), c[i], 7);
      end
      @(negedge clk);
    end

    // Randomized jobs with random bubbles.
    for (int n = 0; n < 6; n++) begin
      int k;
      k = $urandom_range(1, 8);
      rand_beats(k, 2);
      run_job($sformatf("rand%0d", n), k, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
